// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Brief    : Time-multiplexes a 32-bit hex value onto a common-anode
//             multi-digit seven-segment display. The scan is stepped by
//             rising edges of a sampled divided_clk. Optional macro
//             SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  divided_clk,
    input  logic                  enable,
    input  logic [31:0]           data,
    input  logic [7:0]            dot_mask,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int C_IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int C_DATA_W = 4 * NUM_DIGITS;
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(NUM_DIGITS - 1);

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic                  sync3_q, sync3_d;
    logic [C_IDX_W-1:0]    idx_q, idx_d;
    logic [C_DATA_W-1:0]   shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0] dots_q, dots_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  tick;
    logic [3:0]            nibble;
    logic                  dot_sel;
    logic                  blank_sel;
    logic [NUM_DIGITS-1:0] digit_onehot;
    logic [NUM_DIGITS-1:0] lz_flag;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
        if (i == 0) begin : g_lz_digit0
            assign lz_flag[i] = 1'b0;
        end else begin : g_lz_upper
            assign lz_flag[i] = ~|shadow_q[C_DATA_W-1:4*i];
        end
    end
`else
    assign lz_flag = '0;
`endif

    always_comb begin
        sync1_d  = divided_clk;
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        tick     = sync2_q & ~sync3_q;

        idx_d    = idx_q;
        shadow_d = shadow_q;
        dots_d   = dots_q;
        // Shadow reloads only at frame wrap so each frame is self-consistent.
        if (tick && enable) begin
            if (idx_q == C_LAST_IDX) begin
                idx_d    = '0;
                shadow_d = data[C_DATA_W-1:0];
                dots_d   = dot_mask[NUM_DIGITS-1:0];
            end else begin
                idx_d    = idx_q + C_IDX_W'(1);
            end
        end
    end

    always_comb begin
        nibble       = '0;
        dot_sel      = 1'b0;
        blank_sel    = 1'b0;
        digit_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == C_IDX_W'(i)) begin
                nibble          = shadow_q[4*i +: 4];
                dot_sel         = dots_q[i];
                blank_sel       = lz_flag[i];
                digit_onehot[i] = 1'b1;
            end
        end

        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (enable) begin
            an_d  = ~digit_onehot;
            seg_d = blank_sel ? 7'h7F : ~hex7(nibble);
            dp_d  = ~dot_sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            idx_q    <= '0;
            shadow_q <= '0;
            dots_q   <= '0;
            an_q     <= '1;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            sync3_q  <= sync3_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            dots_q   <= dots_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_driver
//  Brief    : Self-checking bench for seg7_scan_driver: vector table, corner
//             sequences and randomized stimulus against a frame-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int N = 8;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ_SEG = 7'h7F;
`else
    localparam logic [6:0] LZ_SEG = 7'h40;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         divided_clk = 1'b0;
    logic         enable = 1'b1;
    logic [31:0]  data = 32'h0;
    logic [7:0]   dot_mask = 8'h0;
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp;

    int total = 0;
    int bad   = 0;

    seg7_scan_driver #(.NUM_DIGITS(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .divided_clk (divided_clk),
        .enable      (enable),
        .data        (data),
        .dot_mask    (dot_mask),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Frame-level reference: current digit, shadow copy and pending advances.
    int          m_idx = 0;
    int          m_wraps = 0;
    int          m_cyc = 0;
    logic [31:0] m_shadow = 32'h0;
    logic [7:0]  m_dots = 8'h0;
    logic        m_prev = 1'b0;
    int          m_due[$];
    logic [7:0]  e_an = 8'hFF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;

    typedef struct {
        logic [31:0] vdata;
        logic [7:0]  vdots;
        int          digit;
        logic [7:0]  ean;
        logic [6:0]  eseg;
        logic        edp;
    } vec_t;

    vec_t       vecs [12];
    logic [6:0] old_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

    function automatic logic [7:0] an_of(input int k);
        logic [7:0] one;
        one = 8'd1;
        return ~(one << k);
    endfunction

    task automatic model_edge();
        logic [31:0] upper;
        if (reset) begin
            m_idx    = 0;
            m_shadow = 32'h0;
            m_dots   = 8'h0;
            m_prev   = 1'b0;
            m_due.delete();
            e_an     = 8'hFF;
            e_seg    = 7'h7F;
            e_dp     = 1'b1;
        end else begin
            m_cyc++;
            if (enable) begin
                upper = m_shadow >> (4 * m_idx);
                e_an  = an_of(m_idx);
                e_seg = ~hex_tab[upper[3:0]];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                if (m_idx > 0 && upper == 32'h0) e_seg = 7'h7F;
`endif
                e_dp  = ~m_dots[m_idx];
            end else begin
                e_an  = 8'hFF;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end
            // A rising edge seen now takes effect on the index two edges later.
            if (m_due.size() > 0 && m_due[0] == m_cyc) begin
                void'(m_due.pop_front());
                if (enable) begin
                    m_idx = (m_idx + 1) % N;
                    if (m_idx == 0) begin
                        m_shadow = data;
                        m_dots   = dot_mask;
                        m_wraps++;
                    end
                end
            end
            if (divided_clk && !m_prev) m_due.push_back(m_cyc + 2);
            m_prev = divided_clk;
        end
    endtask

    task automatic check(input string name, input logic [7:0] ga, input logic [7:0] ea,
                         input logic [6:0] gs, input logic [6:0] es,
                         input logic gd, input logic ed);
        total++;
        if (ga !== ea || gs !== es || gd !== ed) begin
            bad++;
            $display("FAIL %s: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                     name, ga, gs, gd, ea, es, ed);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model", an, e_an, seg, e_seg, dp, e_dp);
    endtask

    task automatic pulse();
        divided_clk = 1'b1;
        repeat (4) step();
        divided_clk = 1'b0;
        repeat (4) step();
    endtask

    task automatic goto_digit(input int digit, input bit need_wrap, input string name);
        int  w0;
        bit  hit;
        w0  = m_wraps;
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            if ((!need_wrap || m_wraps > w0) && m_idx == digit) hit = 1'b1;
            else pulse();
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL %s: timeout reaching digit %0d, at digit %0d", name, digit, m_idx);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got total=%0d want completion", total);
        $fatal(1);
    end

    initial begin
        int i0, i1;

        vecs[0]  = '{32'h12345678, 8'h01, 0, 8'hFE, 7'h00, 1'b0};
        vecs[1]  = '{32'h12345678, 8'h01, 7, 8'h7F, 7'h79, 1'b1};
        vecs[2]  = '{32'h12345678, 8'h01, 3, 8'hF7, 7'h12, 1'b1};
        vecs[3]  = '{32'hFFFFFFFF, 8'h80, 7, 8'h7F, 7'h0E, 1'b0};
        vecs[4]  = '{32'h000000A5, 8'h00, 1, 8'hFD, 7'h08, 1'b1};
        vecs[5]  = '{32'h000000A5, 8'h00, 0, 8'hFE, 7'h12, 1'b1};
        vecs[6]  = '{32'h000000A5, 8'h00, 2, 8'hFB, LZ_SEG, 1'b1};
        vecs[7]  = '{32'h00000000, 8'h04, 2, 8'hFB, LZ_SEG, 1'b0};
        vecs[8]  = '{32'h00000000, 8'h00, 0, 8'hFE, 7'h40, 1'b1};
        vecs[9]  = '{32'h9ABCDEF0, 8'hFF, 5, 8'hDF, 7'h03, 1'b0};
        vecs[10] = '{32'h9ABCDEF0, 8'hFF, 4, 8'hEF, 7'h46, 1'b0};
        vecs[11] = '{32'h00003000, 8'h00, 4, 8'hEF, LZ_SEG, 1'b1};

        // Reset held while divided_clk toggles.
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            divided_clk = ~divided_clk;
            step();
        end
        check("reset_hold", an, 8'hFF, seg, 7'h7F, dp, 1'b1);
        divided_clk = 1'b0;
        reset = 1'b0;
        step();
        check("post_reset_digit0", an, 8'hFE, seg, 7'h40, dp, 1'b1);
        pulse();
        check("post_reset_digit1", an, 8'hFD, seg, LZ_SEG, dp, 1'b1);

        // Vector table.
        for (int v = 0; v < 12; v++) begin
            data     = vecs[v].vdata;
            dot_mask = vecs[v].vdots;
            goto_digit(vecs[v].digit, 1'b1, $sformatf("vec%0d", v));
            check($sformatf("vec%0d", v), an, vecs[v].ean, seg, vecs[v].eseg, dp, vecs[v].edp);
        end

        // Data change mid-frame stays invisible until the wrap.
        data     = 32'h12345678;
        dot_mask = 8'h01;
        goto_digit(3, 1'b1, "midframe_setup");
        data = 32'hFFFFFFFF;
        for (int d = 4; d < 8; d++) begin
            pulse();
            check($sformatf("midframe_old%0d", d), an, an_of(d), seg, old_seg[d-4], dp, 1'b1);
        end
        pulse();
        check("midframe_new0", an, 8'hFE, seg, 7'h0E, dp, 1'b0);

        // divided_clk held high: one advance from its rise, then nothing.
        i0 = m_idx;
        divided_clk = 1'b1;
        repeat (1000) step();
        check("hold_high", an, an_of((i0 + 1) % N), seg, e_seg, dp, e_dp);
        divided_clk = 1'b0;
        repeat (3) step();
        i1 = m_idx;
        divided_clk = 1'b1;
        step();
        check("lat_t0", an, an_of(i1), seg, e_seg, dp, e_dp);
        step();
        check("lat_t1", an, an_of(i1), seg, e_seg, dp, e_dp);
        step();
        check("lat_t2", an, an_of(i1), seg, e_seg, dp, e_dp);
        step();
        check("lat_t3", an, an_of((i1 + 1) % N), seg, e_seg, dp, e_dp);
        divided_clk = 1'b0;
        repeat (4) step();

        // Disable at digit 5 and keep ticking.
        goto_digit(5, 1'b0, "enable_setup");
        enable = 1'b0;
        step();
        check("disable_blank", an, 8'hFF, seg, 7'h7F, dp, 1'b1);
        repeat (50) pulse();
        check("disable_50", an, 8'hFF, seg, 7'h7F, dp, 1'b1);
        enable = 1'b1;
        step();
        check("reenable", an, 8'hDF, seg, e_seg, dp, e_dp);

        // Reset mid-scan takes effect without a clock edge.
        pulse();
        reset = 1'b1;
        #2;
        check("async_reset", an, 8'hFF, seg, 7'h7F, dp, 1'b1);
        for (int k = 0; k < 10; k++) begin
            divided_clk = ~divided_clk;
            step();
        end
        divided_clk = 1'b0;
        reset = 1'b0;
        step();
        check("reset_release", an, 8'hFE, seg, 7'h40, dp, 1'b1);

        // Randomized stimulus against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(2, 0) == 0) divided_clk = ~divided_clk;
            enable = ($urandom_range(15, 0) != 0);
            if ($urandom_range(19, 0) == 0) data = $urandom;
            if ($urandom_range(19, 0) == 0) dot_mask = 8'($urandom);
            reset = ($urandom_range(499, 0) == 0);
            step();
        end
        reset  = 1'b0;
        enable = 1'b1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
